// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow-memory line port between the I-cache and
// D-cache miss/writeback ports. Whole transactions are serialised, ties are
// arbitrated round-robin or D-first, and each port has a saturating
// completion counter for performance measurement.
//
// state | meaning
// IDLE  | no transaction in flight; requests are arbitrated this cycle
// GNT_I | I-cache transaction on the memory port, waiting for mem_ready
// GNT_D | D-cache transaction on the memory port, waiting for mem_ready
module mem_arbiter #(
    parameter int D_PRIORITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_read,
    input  logic             i_write,
    input  logic [27:0]      i_addr,
    input  logic [127:0]     i_wdata,
    output logic [127:0]     i_rdata,
    output logic             i_ready,
    input  logic             d_read,
    input  logic             d_write,
    input  logic [27:0]      d_addr,
    input  logic [127:0]     d_wdata,
    output logic [127:0]     d_rdata,
    output logic             d_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic [27:0]      mem_addr,
    output logic [127:0]     mem_wdata,
    input  logic [127:0]     mem_rdata,
    input  logic             mem_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] cnt_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_gnt;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [27:0]      r_mem_addr;
    logic [127:0]     r_mem_wdata;
    logic [CNT_W-1:0] r_cnt_i;
    logic [CNT_W-1:0] r_cnt_d;

    logic w_req_i;
    logic w_req_d;
    logic w_grant_i;
    logic w_grant_d;
    logic w_done_i;
    logic w_done_d;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

    // Arbitration in IDLE and completion detection in the grant states.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done_i    = 1'b0;
        w_done_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_i && w_req_d) begin
                    // Tie: D-first mode, or hand the grant to the port that did not win last.
                    if ((D_PRIORITY != 0) || (r_last_gnt == PORT_I)) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_grant_i = 1'b1;
                    end
                end else if (w_req_d) begin
                    w_grant_d = 1'b1;
                end else if (w_req_i) begin
                    w_grant_i = 1'b1;
                end
                if (w_grant_d) begin
                    w_state_nxt = GNT_D;
                end else if (w_grant_i) begin
                    w_state_nxt = GNT_I;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    w_done_i    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    w_done_d    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winner's request onto the memory port; held until completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt  <= PORT_I;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_d) begin
            // A simultaneous read and write is treated as a write.
            r_last_gnt  <= PORT_D;
            r_mem_read  <= d_read & ~d_write;
            r_mem_write <= d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
        end else if (w_grant_i) begin
            r_last_gnt  <= PORT_I;
            r_mem_read  <= i_read & ~i_write;
            r_mem_write <= i_write;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= i_wdata;
        end else if (w_done_i || w_done_d) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    // Saturating per-port completion counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_i <= '0;
            r_cnt_d <= '0;
        end else begin
            if (w_done_i && (r_cnt_i != {CNT_W{1'b1}})) begin
                r_cnt_i <= r_cnt_i + 1'b1;
            end
            if (w_done_d && (r_cnt_d != {CNT_W{1'b1}})) begin
                r_cnt_d <= r_cnt_d + 1'b1;
            end
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);
    assign cnt_i     = r_cnt_i;
    assign cnt_d     = r_cnt_d;

    // Read data is shared; only the ready pulse says whose it is.
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_ready   = w_done_i;
    assign d_ready   = w_done_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level arbitration model feeds an
// expected-transaction queue; a monitor pops and checks the memory port,
// ready pulses, busy and counters. A second instance in D-first mode with
// narrow counters covers priority and saturation.
module tb_mem_arbiter;

    localparam int HALF  = 5;
    localparam int D_PRI = 0;

    logic clk = 1'b0;
    always #HALF clk = ~clk;

    int total = 0;
    int bad   = 0;

    // main instance signals
    logic         rst_n;
    logic         i_read, i_write, d_read, d_write;
    logic [27:0]  i_addr, d_addr, mem_addr;
    logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic         i_ready, d_ready, mem_read, mem_write, busy;
    logic         mem_ready, resp_ready, dir_ready, resp_en;
    logic [15:0]  cnt_i, cnt_d;
    assign mem_ready = resp_ready | dir_ready;

    // D-first, 4-bit-counter instance signals
    logic         p_i_read, p_d_read;
    logic [127:0] p_i_rdata, p_d_rdata, p_mem_wdata, p_mem_rdata;
    logic         p_i_ready, p_d_ready, p_mem_read, p_mem_write, p_mem_ready, p_busy;
    logic [27:0]  p_mem_addr;
    logic [3:0]   p_cnt_i, p_cnt_d;

    mem_arbiter #(.D_PRIORITY(D_PRI), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .cnt_i(cnt_i), .cnt_d(cnt_d)
    );

    mem_arbiter #(.D_PRIORITY(1), .CNT_W(4)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .i_read(p_i_read), .i_write(1'b0), .i_addr(28'h0000100), .i_wdata(128'h0),
        .i_rdata(p_i_rdata), .i_ready(p_i_ready),
        .d_read(p_d_read), .d_write(1'b0), .d_addr(28'h0000200), .d_wdata(128'h0),
        .d_rdata(p_d_rdata), .d_ready(p_d_ready),
        .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr),
        .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata), .mem_ready(p_mem_ready),
        .busy(p_busy), .cnt_i(p_cnt_i), .cnt_d(p_cnt_d)
    );

    typedef struct {
        logic         d;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  cnt;
        time          t;
    } txn_t;

    txn_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time; a tie goes to D in D-first
    // mode, otherwise to whichever port did not win the previous grant.
    initial begin : model
        logic        last_d;
        logic        busy_m;
        logic        pick_d;
        logic        ri, rd;
        logic [15:0] ci, cd;
        txn_t        e;
        last_d = 1'b0; busy_m = 1'b0; ci = '0; cd = '0;
        forever begin
            @(posedge clk);
            ri = i_read | i_write;
            rd = d_read | d_write;
            if (!rst_n) begin
                exp_q.delete();
                last_d = 1'b0; busy_m = 1'b0; ci = '0; cd = '0;
            end else if (busy_m) begin
                if (mem_ready) busy_m = 1'b0;
            end else if (ri || rd) begin
                if (ri && rd) pick_d = (D_PRI != 0) || !last_d;
                else          pick_d = rd;
                e.d = pick_d;
                if (pick_d) begin
                    e.wr = d_write; e.addr = d_addr; e.wdata = d_wdata;
                    if (cd != 16'hFFFF) cd = cd + 16'd1;
                    e.cnt = cd;
                end else begin
                    e.wr = i_write; e.addr = i_addr; e.wdata = i_wdata;
                    if (ci != 16'hFFFF) ci = ci + 16'd1;
                    e.cnt = ci;
                end
                e.t = $time;
                exp_q.push_back(e);
                last_d = pick_d;
                busy_m = 1'b1;
            end
        end
    end

    // Monitor: pops an expected transaction when the memory port should start one.
    initial begin : monitor
        logic        in_txn;
        logic        done;
        logic [15:0] mci, mcd;
        txn_t        cur;
        in_txn = 1'b0; mci = '0; mcd = '0;
        cur = '{d: 1'b0, wr: 1'b0, addr: '0, wdata: '0, cnt: '0, t: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_txn = 1'b0; mci = '0; mcd = '0;
            end else begin
                if (!in_txn) begin
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        in_txn = 1'b1;
                        check("grant_time", 128'($time), 128'(cur.t + HALF));
                    end else begin
                        check("idle_mem_op", 128'({mem_read, mem_write}), 128'(0));
                    end
                end
                check("busy", 128'(busy), 128'(in_txn));
                if (in_txn) begin
                    check("mem_read", 128'(mem_read), 128'(!cur.wr));
                    check("mem_write", 128'(mem_write), 128'(cur.wr));
                    check("mem_addr", 128'(mem_addr), 128'(cur.addr));
                    check("mem_wdata", mem_wdata, cur.wdata);
                end
                done = in_txn && mem_ready;
                check("i_ready", 128'(i_ready), 128'(done && !cur.d));
                check("d_ready", 128'(d_ready), 128'(done && cur.d));
                if (done) check("rdata", cur.d ? d_rdata : i_rdata, mem_rdata);
                check("cnt_i", 128'(cnt_i), 128'(mci));
                check("cnt_d", 128'(cnt_d), 128'(mcd));
                if (done) begin
                    if (cur.d) mcd = cur.cnt;
                    else       mci = cur.cnt;
                    in_txn = 1'b0;
                end
            end
        end
    end

    // Slow memory for the main instance: random latency, fresh data each cycle.
    initial begin : responder
        resp_ready = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            resp_ready = resp_en && (mem_read || mem_write) && ($urandom_range(0, 2) == 0);
            mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Slow memory for the D-first instance: answers in the first granted cycle.
    initial begin : responder_p
        p_mem_ready = 1'b0;
        p_mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            p_mem_ready = p_mem_read | p_mem_write;
            p_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    initial begin : watchdog
        #(HALF * 2 * 40000);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input bit is_d, input bit rd, input bit wr);
        if (is_d) begin d_read = rd; d_write = wr; end
        else      begin i_read = rd; i_write = wr; end
    endtask

    // Wait for either ready pulse; optionally scramble D inputs while waiting.
    task automatic wait_ready(input bit scramble, output bit got_d);
        bit ok;
        ok = 1'b0; got_d = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (i_ready || d_ready) begin ok = 1'b1; got_d = d_ready; end
            @(posedge clk); #1;
            if (scramble) begin
                d_addr  = 28'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL ready_timeout: no ready in 200 cycles, required one");
        end
    endtask

    // Random requester: inputs change every cycle; the arbiter must latch at grant.
    task automatic drive_port(input bit is_d, input int n);
        for (int k = 0; k < n; k++) begin
            int gap;
            int op;
            int waitc;
            bit got;
            gap   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            op    = $urandom_range(1, 3);
            waitc = 0;
            got   = 1'b0;
            repeat (gap) begin
                set_req(is_d, 1'b0, 1'b0);
                @(posedge clk); #1;
            end
            set_req(is_d, op[0], op[1]);
            while (!got && waitc < 200) begin
                if (is_d) begin
                    d_addr  = 28'($urandom);
                    d_wdata = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    i_addr  = 28'($urandom);
                    i_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
                @(negedge clk);
                got = is_d ? d_ready : i_ready;
                @(posedge clk); #1;
                waitc++;
            end
            if (!got) begin
                total++; bad++;
                $display("FAIL drv_timeout: port %0d no ready in 200 cycles", is_d);
            end
        end
        set_req(is_d, 1'b0, 1'b0);
    endtask

    initial begin : main
        bit gd;
        int ni, nd, nbusy;
        rst_n = 1'b0; resp_en = 1'b1; dir_ready = 1'b0;
        i_read = 1'b1; i_write = 1'b0; i_addr = 28'h0000010; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        p_i_read = 1'b0; p_d_read = 1'b0;

        // reset with an I read already pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", 128'(mem_read), 128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", mem_wdata, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_cnt", 128'({cnt_i, cnt_d}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready(1'b0, gd);
        check("t1_port", 128'(gd), 128'(0));
        i_read = 1'b0;

        // D write; D inputs change after the grant and must not leak through
        d_write = 1'b1; d_addr = 28'h0000020; d_wdata = {16{8'hA5}};
        wait_ready(1'b1, gd);
        check("t2_port", 128'(gd), 128'(1));
        d_write = 1'b0;
        @(negedge clk);
        check("t2_cnt_d", 128'(cnt_d), 128'(1));
        @(posedge clk); #1;

        // random traffic on both ports
        fork
            drive_port(1'b0, 60);
            drive_port(1'b1, 60);
        join
        repeat (3) begin @(posedge clk); #1; end

        // reset in the middle of a D transaction, then a stale mem_ready
        resp_en = 1'b0;
        d_read = 1'b1; d_addr = 28'h0000ABC;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy) break;
            @(posedge clk); #1;
        end
        check("rstmid_busy", 128'(busy), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b0; d_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; dir_ready = 1'b1;
        @(negedge clk);
        check("stale_d_ready", 128'(d_ready), 128'(0));
        check("stale_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        dir_ready = 1'b0;
        @(negedge clk);
        check("stale_cnt_d", 128'(cnt_d), 128'(0));
        check("stale_cnt_i", 128'(cnt_i), 128'(0));
        @(posedge clk); #1;
        resp_en = 1'b1;

        // continuous contention after reset: round-robin starting with D
        i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(1'b0, gd);
            check("rr_order", 128'(gd), 128'((k % 2) == 0));
        end
        i_read = 1'b0; d_read = 1'b0;
        @(negedge clk);
        check("rr_cnt_i", 128'(cnt_i), 128'(2));
        check("rr_cnt_d", 128'(cnt_d), 128'(2));
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        // D-first instance: contention always goes to D; counters saturate
        p_i_read = 1'b1; p_d_read = 1'b1;
        ni = 0; nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (p_i_ready) ni++;
            if (p_d_ready) begin
                nd++;
                check("p_d_rdata", p_d_rdata, p_mem_rdata);
                check("p_d_addr", 128'(p_mem_addr), 128'(28'h0000200));
            end
        end
        check("p_i_starved", 128'(ni), 128'(0));
        check("p_d_served", 128'(nd >= 16), 128'(1));
        check("p_cnt_d_sat", 128'(p_cnt_d), 128'(4'hF));
        check("p_cnt_i_zero", 128'(p_cnt_i), 128'(0));
        @(posedge clk); #1;
        p_d_read = 1'b0;
        ni = 0;
        repeat (40) begin
            @(negedge clk);
            if (p_i_ready) begin
                ni++;
                check("p_i_rdata", p_i_rdata, p_mem_rdata);
                check("p_i_addr", 128'(p_mem_addr), 128'(28'h0000100));
            end
        end
        check("p_i_served", 128'(ni >= 16), 128'(1));
        check("p_cnt_i_sat", 128'(p_cnt_i), 128'(4'hF));
        check("p_cnt_d_hold", 128'(p_cnt_d), 128'(4'hF));
        @(posedge clk); #1;
        p_i_read = 1'b0;
        nbusy = 0;
        repeat (3) begin
            @(negedge clk);
            if (p_busy) nbusy++;
        end
        check("p_idle_busy", 128'(p_busy), 128'(0));
        check("p_idle_op", 128'({p_mem_read, p_mem_write}), 128'(0));
        check("p_wdata", p_mem_wdata, 128'(0));
        check("p_busy_drain", 128'(nbusy <= 1), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow-memory line port (128-bit data, line address [31:4], ready handshake) between the I-cache and D-cache miss/writeback ports.
- Lets CHIP run against a single unified slow memory instead of separate I and D memories.
- Sits between the two caches and the memory interface at the CHIP boundary.
- Serialises whole transactions, arbitrates ties, and keeps per-port transaction counters for performance measurement.

Parameters:
- D_PRIORITY, 0: tie-break mode. 0 = round-robin between I and D; 1 = D always wins ties.
- CNT_W, 16: width of each saturating transaction counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- i_read  input  1  I-cache line read request
- i_write  input  1  I-cache line write request
- i_addr  input  28  I-cache line address [31:4]
- i_wdata  input  128  I-cache write line
- i_rdata  output  128  read line to I-cache
- i_ready  output  1  I transaction complete, one-cycle pulse
- d_read  input  1  D-cache line read request
- d_write  input  1  D-cache line write request
- d_addr  input  28  D-cache line address [31:4]
- d_wdata  input  128  D-cache write line
- d_rdata  output  128  read line to D-cache
- d_ready  output  1  D transaction complete, one-cycle pulse
- mem_read  output  1  read request to slow memory
- mem_write  output  1  write request to slow memory
- mem_addr  output  28  line address to slow memory
- mem_wdata  output  128  write line to slow memory
- mem_rdata  input  128  read line from slow memory
- mem_ready  input  1  slow memory completion pulse
- busy  output  1  a transaction is in flight
- cnt_i  output  CNT_W  completed I transactions, saturating
- cnt_d  output  CNT_W  completed D transactions, saturating

Behaviour:
- States: IDLE, GNT_I, GNT_D. A 1-bit last_gnt register records the last granted port.
- Reset (sync, rst_n=0 at a rising edge):
  - state=IDLE, last_gnt=I.
  - mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
  - busy=0, cnt_i=cnt_d=0, i_ready=d_ready=0.
- Request definition: req_x = x_read | x_write.
  - If both x_read and x_write are asserted, the request is treated as a write; mem_read stays 0.
- IDLE arbitration, evaluated each cycle:
  - Only req_d: go to GNT_D.
  - Only req_i: go to GNT_I.
  - Both asserted: if D_PRIORITY=1, grant D. Otherwise grant the port != last_gnt, so the first tie after reset goes to D.
  - Neither asserted: stay in IDLE.
- On the grant edge:
  - Latch the winner's op, addr and wdata into registered mem_* outputs.
  - Update last_gnt.
  - Set busy=1.
  - mem_* are asserted in the cycle after the request is sampled (1-cycle grant latency).
- GNT_x:
  - mem_* are held stable and ignore further changes on the x_* inputs.
  - The x_ready output is combinational: x_ready = mem_ready & (state==GNT_x). The other port's ready stays 0.
  - i_rdata and d_rdata are both driven directly by mem_rdata; only the ready signal qualifies the data.
- Completion: when mem_ready=1 in GNT_x:
  - Next state is IDLE; mem_read, mem_write and busy drop to 0 at that edge.
  - cnt_x increments, saturating at all-ones.
  - The earliest next grant has mem_* asserted 2 cycles after the mem_ready cycle.
- mem_ready while IDLE (stale, e.g. after a reset mid-transaction) is ignored: no ready is forwarded and no counter changes.
- Requester drops its request mid-transaction: the downstream transaction still completes, and x_ready still pulses.
- Reset while in GNT_x: outputs return to reset values the next cycle. The caller must wait for the slow memory to go quiet.
- No starvation: in round-robin mode each port waits at most one other transaction under continuous contention.

Test Plan:
- Reset with i_read=1, addr 0x0000010 held -> mem_read=0 during reset. At the first edge after reset, state=GNT_I. The next cycle shows mem_read=1, mem_addr=0x0000010. On mem_ready: i_ready=1, i_rdata=mem_rdata, d_ready=0, cnt_i=1.
- d_write=1, d_addr=0x0000020, d_wdata=128'hA5..A5 -> mem_write=1, mem_addr=0x0000020, mem_wdata=A5..A5. These stay stable even when d_addr changes mid-transaction. d_ready pulses once and cnt_d=1.
- i_read and d_read asserted together, continuously, with D_PRIORITY=0 -> grant order D, I, D, I. After 4 completions cnt_d=2, cnt_i=2, with exactly 1 idle cycle between transactions.
- The same contention with D_PRIORITY=1 -> D is granted every time and cnt_i stays 0.
- d_read and d_write both set -> mem_write=1, mem_read=0.
- rst_n=0 for 1 cycle mid-GNT_D, then a late mem_ready pulse in IDLE -> d_ready=0, cnt_d=0, busy=0. Preload cnt_i=0xFFFF via 65535 completions, then one more I completion -> cnt_i stays 0xFFFF.
